// File: rtl/pipelined_vec_op_pkg.sv
// Shared types for the pipelined vector engine: FSM states, op encodings
// and the signed-overflow classification used by the saturating datapath.
package vec_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // top2 holds the two MSBs of a sign-extended result; a mismatch is overflow,
  // and the extra MSB tells which rail to clamp to.
  function automatic sat_e sat_kind(input logic [1:0] top2);
    case (top2)
      2'b01:   return SAT_POS;
      2'b10:   return SAT_NEG;
      default: return SAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_vec_op_if.sv
// Control handshake plus the three external RAM ports of the vector engine.
interface pipelined_vec_op_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  import vec_pipe_pkg::*;

  // start is a one-cycle request, taken only when the engine is idle and not
  // busy; finish is a one-cycle completion pulse; RAM read data is valid
  // exactly RD_LAT cycles after the matching a_en/b_en strobe.
  logic              start;
  logic [ADDR_W:0]   len;
  logic              op;
  logic [ADDR_W-1:0] a_addr;
  logic              a_en;
  logic [DATA_W-1:0] a_q;
  logic [ADDR_W-1:0] b_addr;
  logic              b_en;
  logic [DATA_W-1:0] b_q;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [DATA_W-1:0] c_data;
  logic              busy;
  logic              finish;
  logic [31:0]       return_val;

  modport slave (
    input  start, len, op, a_q, b_q,
    output a_addr, a_en, b_addr, b_en, c_addr, c_we, c_data, busy, finish, return_val
  );

  modport master (
    output start, len, op, a_q, b_q,
    input  a_addr, a_en, b_addr, b_en, c_addr, c_we, c_data, busy, finish, return_val
  );

endinterface

// File: rtl/pipelined_vec_op_valid_shift.sv
// Valid bit + element index delay line matching the RAM read latency.
module pipe_valid_shift #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        idx_q[k]   <= idx_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/pipelined_vec_op.sv
// Vector engine c[i] = a[i] OP b[i]: issues one RAM read every II cycles,
// writes each result RD_LAT+1 cycles after its issue, and accumulates a checksum.
module pipelined_vec_op
  import vec_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int II     = 3,
  parameter int RD_LAT = 2,
  parameter int SAT    = 0
) (
  input  logic               clk,
  input  logic               reset,
  pipelined_vec_op_if.slave  bus_io,
  output state_e             dbg_state_o
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      II_LAST = 4'(II - 1);

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic              op_q;
  logic [3:0]        ii_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic [ADDR_W-1:0] c_addr_q;
  logic              c_we_q;
  logic [DATA_W-1:0] c_data_q;
  logic              busy_q;
  logic              finish_q;
  logic [31:0]       ret_q;

  logic              pv_valid;
  logic [ADDR_W-1:0] pv_idx;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   last_idx;
  logic              last_issue;
  logic              accept;
  logic [DATA_W:0]   a_ext, b_ext, wide;
  sat_e              kind;
  logic [DATA_W-1:0] res_d;
  logic [31:0]       c_ext;

  assign len_clamped = (bus_io.len > LEN_MAX) ? LEN_MAX : bus_io.len;
  assign last_idx    = len_q - 1'b1;
  assign last_issue  = ({1'b0, addr_q} == last_idx);
  assign accept      = bus_io.start && (state_q == IDLE) && !busy_q;

  pipe_valid_shift #(.DEPTH(RD_LAT), .IDX_W(ADDR_W)) u_valid_shift (
    .clk     (clk),
    .clr_n_i (reset),
    .valid_i (en_q),
    .idx_i   (addr_q),
    .valid_o (pv_valid),
    .idx_o   (pv_idx)
  );

  // Sign-extended operands give one guard bit for overflow detection.
  always_comb begin
    a_ext = {bus_io.a_q[DATA_W-1], bus_io.a_q};
    b_ext = {bus_io.b_q[DATA_W-1], bus_io.b_q};
    wide  = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    kind  = sat_kind(wide[DATA_W -: 2]);
    res_d = wide[DATA_W-1:0];
    if (SAT != 0 && kind == SAT_POS) res_d = {1'b0, {(DATA_W-1){1'b1}}};
    if (SAT != 0 && kind == SAT_NEG) res_d = {1'b1, {(DATA_W-1){1'b0}}};
  end

  generate
    if (DATA_W >= 32) begin : g_trunc
      assign c_ext = c_data_q[31:0];
    end else begin : g_zext
      assign c_ext = {{(32-DATA_W){1'b0}}, c_data_q};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      op_q     <= OP_ADD;
      ii_q     <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      c_addr_q <= '0;
      c_we_q   <= 1'b0;
      c_data_q <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      ret_q    <= '0;
    end else begin
      en_q     <= 1'b0;
      finish_q <= 1'b0;
      c_we_q   <= pv_valid;
      if (pv_valid) begin
        c_addr_q <= pv_idx;
        c_data_q <= res_d;
      end
      if (c_we_q)   ret_q  <= ret_q + c_ext;
      if (finish_q) busy_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          len_q  <= len_clamped;
          op_q   <= bus_io.op;
          ret_q  <= '0;
          busy_q <= 1'b1;
          ii_q   <= '0;
          addr_q <= '0;
          if (len_clamped == '0) state_q <= DONE;
          else begin
            state_q <= ISSUE;
            en_q    <= 1'b1;
          end
        end
        // Issue slots fall on ii_q == 0; the index never steps past len-1.
        ISSUE: begin
          if (ii_q == '0 && last_issue) state_q <= DRAIN;
          else if (ii_q == II_LAST) begin
            ii_q   <= '0;
            addr_q <= addr_q + 1'b1;
            en_q   <= 1'b1;
          end else ii_q <= ii_q + 1'b1;
        end
        DRAIN: if (pv_valid && pv_idx == last_idx[ADDR_W-1:0]) state_q <= DONE;
        DONE: begin
          finish_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.a_addr     = addr_q;
  assign bus_io.a_en       = en_q;
  assign bus_io.b_addr     = addr_q;
  assign bus_io.b_en       = en_q;
  assign bus_io.c_addr     = c_addr_q;
  assign bus_io.c_we       = c_we_q;
  assign bus_io.c_data     = c_data_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.finish     = finish_q;
  assign bus_io.return_val = ret_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_pipelined_vec_op.sv
// Directed bench for pipelined_vec_op: four parameterisations share one RAM image.
`timescale 1ns/1ps
module tb_pipelined_vec_op;
  import vec_pipe_pkg::*;

  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_vec_op_if #(.DATA_W(32), .ADDR_W(2)) if0 ();
  pipelined_vec_op_if #(.DATA_W(32), .ADDR_W(2)) if1 ();
  pipelined_vec_op_if #(.DATA_W(8),  .ADDR_W(2)) if2 ();
  pipelined_vec_op_if #(.DATA_W(8),  .ADDR_W(2)) if3 ();
  state_e st0, st1, st2, st3;

  pipelined_vec_op #(.DATA_W(32), .ADDR_W(2), .II(3), .RD_LAT(2), .SAT(0)) u0 (
    .clk(clk), .reset(reset), .bus_io(if0.slave), .dbg_state_o(st0));
  pipelined_vec_op #(.DATA_W(32), .ADDR_W(2), .II(1), .RD_LAT(2), .SAT(0)) u1 (
    .clk(clk), .reset(reset), .bus_io(if1.slave), .dbg_state_o(st1));
  pipelined_vec_op #(.DATA_W(8), .ADDR_W(2), .II(1), .RD_LAT(1), .SAT(1)) u2 (
    .clk(clk), .reset(reset), .bus_io(if2.slave), .dbg_state_o(st2));
  pipelined_vec_op #(.DATA_W(8), .ADDR_W(2), .II(2), .RD_LAT(3), .SAT(0)) u3 (
    .clk(clk), .reset(reset), .bus_io(if3.slave), .dbg_state_o(st3));

  // RAM models: data returns RD_LAT cycles after the strobe, poison otherwise
  logic [31:0] a_mem [4];
  logic [31:0] b_mem [4];
  logic [31:0] ra0 [2], rb0 [2], ra1 [2], rb1 [2];
  logic [7:0]  ra2, rb2;
  logic [7:0]  ra3 [3], rb3 [3];

  always @(posedge clk) begin
    ra0[0] <= if0.a_en ? a_mem[if0.a_addr] : POISON;
    rb0[0] <= if0.b_en ? b_mem[if0.b_addr] : POISON;
    ra0[1] <= ra0[0];
    rb0[1] <= rb0[0];
    ra1[0] <= if1.a_en ? a_mem[if1.a_addr] : POISON;
    rb1[0] <= if1.b_en ? b_mem[if1.b_addr] : POISON;
    ra1[1] <= ra1[0];
    rb1[1] <= rb1[0];
    ra2    <= if2.a_en ? a_mem[if2.a_addr][7:0] : 8'hEE;
    rb2    <= if2.b_en ? b_mem[if2.b_addr][7:0] : 8'hEE;
    ra3[0] <= if3.a_en ? a_mem[if3.a_addr][7:0] : 8'hEE;
    rb3[0] <= if3.b_en ? b_mem[if3.b_addr][7:0] : 8'hEE;
    ra3[1] <= ra3[0];
    rb3[1] <= rb3[0];
    ra3[2] <= ra3[1];
    rb3[2] <= rb3[1];
  end

  assign if0.a_q = ra0[1];
  assign if0.b_q = rb0[1];
  assign if1.a_q = ra1[1];
  assign if1.b_q = rb1[1];
  assign if2.a_q = ra2;
  assign if2.b_q = rb2;
  assign if3.a_q = ra3[2];
  assign if3.b_q = rb3[2];

  // write / finish / issue monitor (only one unit runs at a time)
  int          wr_cnt = 0;
  int          fin_cnt = 0;
  int          en_cnt = 0;
  int          fin_cyc = 0;
  int          wr_addr_log [64];
  int          wr_cyc_log  [64];
  logic [31:0] wr_data_log [64];

  always @(negedge clk) begin
    if ((if0.c_we || if1.c_we || if2.c_we || if3.c_we) && wr_cnt < 64) begin
      if (if0.c_we) begin
        wr_addr_log[wr_cnt] = int'(if0.c_addr);
        wr_data_log[wr_cnt] = if0.c_data;
      end else if (if1.c_we) begin
        wr_addr_log[wr_cnt] = int'(if1.c_addr);
        wr_data_log[wr_cnt] = if1.c_data;
      end else if (if2.c_we) begin
        wr_addr_log[wr_cnt] = int'(if2.c_addr);
        wr_data_log[wr_cnt] = 32'(if2.c_data);
      end else begin
        wr_addr_log[wr_cnt] = int'(if3.c_addr);
        wr_data_log[wr_cnt] = 32'(if3.c_data);
      end
      wr_cyc_log[wr_cnt] = cyc;
      wr_cnt = wr_cnt + 1;
    end
    if (if0.a_en || if1.a_en || if2.a_en || if3.a_en) en_cnt = en_cnt + 1;
    if (if0.finish || if1.finish || if2.finish || if3.finish) begin
      fin_cnt = fin_cnt + 1;
      fin_cyc = cyc;
    end
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  int s_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int base, input int k, input logic [31:0] exp);
    chk($sformatf("%s c[%0d] addr", tag, k), 32'(wr_addr_log[base+k]), 32'(k));
    chk($sformatf("%s c[%0d] data", tag, k), wr_data_log[base+k], exp);
  endtask

  // driver tasks
  task automatic start_run(input int unit, input logic [2:0] len, input logic op);
    @(negedge clk);
    case (unit)
      0:       begin if0.start = 1'b1; if0.len = len; if0.op = op; end
      1:       begin if1.start = 1'b1; if1.len = len; if1.op = op; end
      2:       begin if2.start = 1'b1; if2.len = len; if2.op = op; end
      default: begin if3.start = 1'b1; if3.len = len; if3.op = op; end
    endcase
    s_cyc = cyc;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    if3.start = 1'b0;
  endtask

  task automatic wait_finish(input int base, input string tag);
    int n = 0;
    while (fin_cnt == base && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, " finish seen"}, 32'(fin_cnt != base), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, wb, fb, eb, n;
    if0.start = 1'b0; if0.len = '0; if0.op = 1'b0;
    if1.start = 1'b0; if1.len = '0; if1.op = 1'b0;
    if2.start = 1'b0; if2.len = '0; if2.op = 1'b0;
    if3.start = 1'b0; if3.len = '0; if3.op = 1'b0;
    a_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_mem = '{32'd10, 32'd20, 32'd30, 32'd40};
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy",   32'(if0.busy), 32'd0);
    chk("rst finish", 32'(if0.finish), 32'd0);
    chk("rst a_en",   32'(if0.a_en), 32'd0);
    chk("rst c_we",   32'(if0.c_we), 32'd0);
    chk("rst ret",    if0.return_val, 32'd0);
    chk("rst state",  32'(st0), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // 1: II=3 add
    wb = wr_cnt; fb = fin_cnt; eb = en_cnt;
    start_run(0, 3'd4, OP_ADD);
    s = s_cyc;
    wait_finish(fb, "t1");
    chk("t1 writes", 32'(wr_cnt - wb), 32'd4);
    chk("t1 issues", 32'(en_cnt - eb), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr("t1", wb, k, 32'(11 * (k + 1)));
    chk("t1 finish cycle", 32'(fin_cyc - s), 32'd14);
    chk("t1 return_val", if0.return_val, 32'd110);
    chk("t1 busy after", 32'(if0.busy), 32'd0);

    // 2: II=1 sub, back-to-back writes
    a_mem = '{32'd5, 32'd5, 32'd5, 32'd5};
    b_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    wb = wr_cnt; fb = fin_cnt;
    start_run(1, 3'd4, OP_SUB);
    s = s_cyc;
    wait_finish(fb, "t2");
    chk("t2 writes", 32'(wr_cnt - wb), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr("t2", wb, k, 32'(4 - k));
    chk("t2 write span", 32'(wr_cyc_log[wb+3] - wr_cyc_log[wb]), 32'd3);
    chk("t2 finish cycle", 32'(fin_cyc - s), 32'd8);
    chk("t2 return_val", if1.return_val, 32'd10);

    // 3: 8-bit saturate vs wrap
    a_mem[0] = 32'h7F; b_mem[0] = 32'h01;
    wb = wr_cnt; fb = fin_cnt;
    start_run(2, 3'd1, OP_ADD);
    s = s_cyc;
    wait_finish(fb, "t3a");
    chk("t3 sat add", wr_data_log[wb], 32'h7F);
    chk("t3 sat finish cycle", 32'(fin_cyc - s), 32'd4);
    chk("t3 sat ret", if2.return_val, 32'h7F);
    wb = wr_cnt; fb = fin_cnt;
    start_run(3, 3'd1, OP_ADD);
    s = s_cyc;
    wait_finish(fb, "t3b");
    chk("t3 wrap add", wr_data_log[wb], 32'h80);
    chk("t3 wrap finish cycle", 32'(fin_cyc - s), 32'd6);
    a_mem[0] = 32'h80;
    wb = wr_cnt; fb = fin_cnt;
    start_run(2, 3'd1, OP_SUB);
    wait_finish(fb, "t3c");
    chk("t3 sat sub", wr_data_log[wb], 32'h80);
    chk("t3 sat sub ret", if2.return_val, 32'h80);
    wb = wr_cnt; fb = fin_cnt;
    start_run(3, 3'd1, OP_SUB);
    wait_finish(fb, "t3d");
    chk("t3 wrap sub", wr_data_log[wb], 32'h7F);

    // 4: len == 0
    wb = wr_cnt; fb = fin_cnt; eb = en_cnt;
    start_run(0, 3'd0, OP_ADD);
    s = s_cyc;
    wait_finish(fb, "t4");
    chk("t4 writes", 32'(wr_cnt - wb), 32'd0);
    chk("t4 issues", 32'(en_cnt - eb), 32'd0);
    chk("t4 finish cycle", 32'(fin_cyc - s), 32'd2);
    chk("t4 return_val", if0.return_val, 32'd0);

    // 5: reset mid-ISSUE after two writes
    a_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_mem = '{32'd10, 32'd20, 32'd30, 32'd40};
    wb = wr_cnt; fb = fin_cnt;
    start_run(0, 3'd4, OP_ADD);
    n = 0;
    while (wr_cnt - wb < 2 && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5 two writes", 32'(wr_cnt - wb), 32'd2);
    chk("t5 state before reset", 32'(st0), 32'(ISSUE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t5 a_en", 32'(if0.a_en), 32'd0);
    chk("t5 c_we", 32'(if0.c_we), 32'd0);
    chk("t5 busy", 32'(if0.busy), 32'd0);
    chk("t5 state", 32'(st0), 32'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("t5 no late writes", 32'(wr_cnt - wb), 32'd2);
    chk("t5 no finish", 32'(fin_cnt - fb), 32'd0);
    wb = wr_cnt; fb = fin_cnt;
    start_run(0, 3'd4, OP_ADD);
    s = s_cyc;
    wait_finish(fb, "t5 rerun");
    chk("t5 rerun writes", 32'(wr_cnt - wb), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr("t5", wb, k, 32'(11 * (k + 1)));
    chk("t5 rerun finish cycle", 32'(fin_cyc - s), 32'd14);
    chk("t5 rerun return_val", if0.return_val, 32'd110);

    // 6: start while busy ignored, then back-to-back run
    wb = wr_cnt; fb = fin_cnt;
    start_run(0, 3'd4, OP_ADD);
    s = s_cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if0.start = 1'b1; if0.len = 3'd1; if0.op = OP_SUB;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    wait_finish(fb, "t6a");
    chk("t6a writes", 32'(wr_cnt - wb), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr("t6a", wb, k, 32'(11 * (k + 1)));
    chk("t6a finish cycle", 32'(fin_cyc - s), 32'd14);
    chk("t6a return_val", if0.return_val, 32'd110);
    wb = wr_cnt; fb = fin_cnt;
    start_run(0, 3'd2, OP_SUB);
    s = s_cyc;
    wait_finish(fb, "t6b");
    repeat (3) @(posedge clk);
    #2;
    chk("t6b single finish", 32'(fin_cnt - fb), 32'd1);
    chk("t6b writes", 32'(wr_cnt - wb), 32'd2);
    chk_wr("t6b", wb, 0, 32'hFFFF_FFF7);
    chk_wr("t6b", wb, 1, 32'hFFFF_FFEE);
    chk("t6b finish cycle", 32'(fin_cyc - s), 32'd8);
    chk("t6b return_val", if0.return_val, 32'hFFFF_FFE5);

    // 7: len above DEPTH clamps to DEPTH
    wb = wr_cnt; fb = fin_cnt; eb = en_cnt;
    start_run(1, 3'd7, OP_ADD);
    wait_finish(fb, "t7");
    chk("t7 writes", 32'(wr_cnt - wb), 32'd4);
    chk("t7 issues", 32'(en_cnt - eb), 32'd4);
    chk_wr("t7", wb, 3, 32'd44);
    chk("t7 return_val", if1.return_val, 32'd110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
